// File: rtl/memory_unit_pkg.sv
// Shared constants and helpers for the status-memory family.
// Holds default sizes, overwrite-policy codes and the occupancy-width helper.
package memory_unit_pkg;

  localparam int DEF_WIDTH = 35;
  localparam int DEF_DEPTH = 8;

  localparam bit MODE_DROP_NEW = 1'b0;
  localparam bit MODE_DROP_OLD = 1'b1;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer with synchronous clear and increment.
// Wraps on an explicit compare, so DEPTH need not be a power of two.
module wrap_ptr #(
  parameter int DEPTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/memory_log_buffer.sv
// Circular history of the last DEPTH status words with FIFO read-back,
// a "latest word" output, occupancy flags and a selectable full policy.
module memory_log_buffer
  import memory_unit_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit OVERWRITE = MODE_DROP_OLD
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    clr,
  input  logic                    wren,
  input  logic [WIDTH-1:0]        din,
  input  logic                    rden,
  output logic [WIDTH-1:0]        dout,
  output logic                    dvalid,
  output logic [WIDTH-1:0]        last,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;
  logic             drop_old;
  logic             ovf_set;
  logic             udf_set;
  logic [CW-1:0]    count_nxt;

  // A read alongside a write when full frees the slot, so only a lone write
  // while full counts as an overflow.
  always_comb begin
    do_rd     = rden && !empty;
    udf_set   = rden && empty;
    ovf_set   = wren && full && !rden;
    drop_old  = ovf_set && (OVERWRITE == MODE_DROP_OLD);
    do_wr     = wren && (!full || rden || drop_old);
    count_nxt = count;
    if (do_wr && !do_rd && !drop_old) begin
      count_nxt = count + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_nxt = count - 1'b1;
    end
  end

  wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk  (clk),
    .arst (arst),
    .clr  (clr),
    .inc  (do_wr),
    .ptr  (wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk  (clk),
    .arst (arst),
    .clr  (clr),
    .inc  (do_rd || drop_old),
    .ptr  (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (do_wr && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Clear empties the buffer but keeps dout and last as seen by the display path.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dvalid    <= 1'b0;
      dout      <= '0;
      last      <= '0;
    end else if (clr) begin
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dvalid    <= 1'b0;
    end else begin
      count  <= count_nxt;
      empty  <= (count_nxt == '0);
      full   <= (count_nxt == CW'(DEPTH));
      dvalid <= do_rd;
      if (do_rd) begin
        dout <= mem[rd_ptr];
      end
      if (do_wr) begin
        last <= din;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end
      if (udf_set) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_log_buffer.sv
// Scoreboard bench for memory_log_buffer: instance 0 overwrites the oldest
// entry when full, instance 1 drops the new word.
module tb_memory_log_buffer;
  import memory_unit_pkg::*;

  localparam int W  = 35;
  localparam int D  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         arst;
  logic         clr [2];
  logic         wren [2];
  logic         rden [2];
  logic [W-1:0] din [2];
  logic [W-1:0] dout [2];
  logic [W-1:0] last [2];
  logic         dvalid [2];
  logic         empty [2];
  logic         full [2];
  logic         overflow [2];
  logic         underflow [2];
  logic [CW-1:0] count [2];

  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  logic [W-1:0] last_m [2];
  logic [W-1:0] exp_dout [2];
  logic         exp_vld [2];
  logic         ovf_m [2];
  logic         udf_m [2];
  int tests;
  int fails;

  always #5 clk = ~clk;

  memory_log_buffer #(.WIDTH(W), .DEPTH(D), .OVERWRITE(MODE_DROP_OLD)) u_ovw (
    .clk(clk), .arst(arst), .clr(clr[0]), .wren(wren[0]), .din(din[0]), .rden(rden[0]),
    .dout(dout[0]), .dvalid(dvalid[0]), .last(last[0]), .count(count[0]),
    .empty(empty[0]), .full(full[0]), .overflow(overflow[0]), .underflow(underflow[0])
  );

  memory_log_buffer #(.WIDTH(W), .DEPTH(D), .OVERWRITE(MODE_DROP_NEW)) u_drp (
    .clk(clk), .arst(arst), .clr(clr[1]), .wren(wren[1]), .din(din[1]), .rden(rden[1]),
    .dout(dout[1]), .dvalid(dvalid[1]), .last(last[1]), .count(count[1]),
    .empty(empty[1]), .full(full[1]), .overflow(overflow[1]), .underflow(underflow[1])
  );

  function automatic int msize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_reset(input bit keep_out);
    q0.delete();
    q1.delete();
    for (int s = 0; s < 2; s++) begin
      if (!keep_out) begin
        last_m[s]   = '0;
        exp_dout[s] = '0;
      end
      exp_vld[s] = 1'b0;
      ovf_m[s]   = 1'b0;
      udf_m[s]   = 1'b0;
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset(1'b0);
  endtask

  // Drive one cycle on instance s; writes push to the scoreboard, reads pop it.
  task automatic drive(input int s, input logic w, input logic [W-1:0] d, input logic r);
    int sz;
    logic [W-1:0] tmp;
    sz = msize(s);
    wren[s] = w;
    din[s]  = d;
    rden[s] = r;
    exp_vld[s] = r && (sz != 0);
    if (exp_vld[s]) begin
      if (s == 0) exp_dout[s] = q0.pop_front();
      else        exp_dout[s] = q1.pop_front();
    end
    if (r && sz == 0) udf_m[s] = 1'b1;
    if (w) begin
      if (sz == D && !r) begin
        ovf_m[s] = 1'b1;
        if (s == 0) begin
          tmp = q0.pop_front();
          q0.push_back(d);
          last_m[s] = d;
        end
      end else begin
        if (s == 0) q0.push_back(d);
        else        q1.push_back(d);
        last_m[s] = d;
      end
    end
    @(posedge clk);
    #1;
    wren[s] = 1'b0;
    rden[s] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      tests++;
      if (count[s] !== '0 || empty[s] !== 1'b1 || full[s] !== 1'b0) begin
        fails++;
        $display("FAIL reset_occ[%0d]: count=%0d empty=%b full=%b, want 0/1/0", s, count[s], empty[s], full[s]);
      end
      tests++;
      if (dout[s] !== '0 || last[s] !== '0 || dvalid[s] !== 1'b0) begin
        fails++;
        $display("FAIL reset_data[%0d]: dout=%0h last=%0h dvalid=%b, want 0", s, dout[s], last[s], dvalid[s]);
      end
      tests++;
      if (overflow[s] !== 1'b0 || underflow[s] !== 1'b0) begin
        fails++;
        $display("FAIL reset_flags[%0d]: ovf=%b udf=%b, want 0", s, overflow[s], underflow[s]);
      end
    end
  endtask

  task automatic fill(input int s);
    for (int i = 1; i <= D; i++) begin
      drive(s, 1'b1, W'(i), 1'b0);
      tests++;
      if (int'(count[s]) !== msize(s) || dvalid[s] !== 1'b0) begin
        fails++;
        $display("FAIL fill_count[%0d]: count=%0d dvalid=%b, want %0d/0", s, count[s], dvalid[s], msize(s));
      end
    end
  endtask

  task automatic drain(input int s, input int first);
    for (int i = 0; i < D; i++) begin
      drive(s, 1'b0, '0, 1'b1);
      tests++;
      if (dvalid[s] !== 1'b1 || dout[s] !== exp_dout[s] || dout[s] !== W'(first + i)) begin
        fails++;
        $display("FAIL drain_pop[%0d]: dout=%0d dvalid=%b, want %0d/1", s, dout[s], dvalid[s], first + i);
      end
    end
    tests++;
    if (empty[s] !== 1'b1 || count[s] !== '0) begin
      fails++;
      $display("FAIL drain_empty[%0d]: empty=%b count=%0d, want 1/0", s, empty[s], count[s]);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    fill(0);
    tests++;
    if (full[0] !== 1'b1 || last[0] !== W'(8) || empty[0] !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: full=%b last=%0d empty=%b, want 1/8/0", full[0], last[0], empty[0]);
    end
    drain(0, 1);
    drive(0, 1'b0, '0, 1'b0);
    tests++;
    if (dvalid[0] !== 1'b0 || dout[0] !== W'(8)) begin
      fails++;
      $display("FAIL dout_hold: dout=%0d dvalid=%b, want 8/0", dout[0], dvalid[0]);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    fill(0);
    drive(0, 1'b1, W'(9), 1'b0);
    tests++;
    if (overflow[0] !== ovf_m[0] || overflow[0] !== 1'b1 || count[0] !== CW'(8) || last[0] !== W'(9)) begin
      fails++;
      $display("FAIL ovw_write: ovf=%b count=%0d last=%0d, want 1/8/9", overflow[0], count[0], last[0]);
    end
    drain(0, 2);
  endtask

  task automatic test_drop();
    do_reset();
    fill(1);
    drive(1, 1'b1, W'(9), 1'b0);
    tests++;
    if (overflow[1] !== 1'b1 || count[1] !== CW'(8) || last[1] !== last_m[1] || last[1] !== W'(8)) begin
      fails++;
      $display("FAIL drop_write: ovf=%b count=%0d last=%0d, want 1/8/8", overflow[1], count[1], last[1]);
    end
    drain(1, 1);
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 10; i < 13; i++) drive(0, 1'b1, W'(i), 1'b0);
    drive(0, 1'b1, W'(13), 1'b1);
    tests++;
    if (count[0] !== CW'(3) || dvalid[0] !== 1'b1 || dout[0] !== W'(10)) begin
      fails++;
      $display("FAIL rw_mid: count=%0d dvalid=%b dout=%0d, want 3/1/10", count[0], dvalid[0], dout[0]);
    end
    for (int i = 11; i < 14; i++) begin
      drive(0, 1'b0, '0, 1'b1);
      tests++;
      if (dout[0] !== exp_dout[0] || dout[0] !== W'(i) || dvalid[0] !== 1'b1) begin
        fails++;
        $display("FAIL rw_order: dout=%0d dvalid=%b, want %0d/1", dout[0], dvalid[0], i);
      end
    end

    do_reset();
    fill(0);
    drive(0, 1'b1, W'(9), 1'b1);
    tests++;
    if (overflow[0] !== 1'b0 || count[0] !== CW'(8) || dout[0] !== W'(1) || last[0] !== W'(9)) begin
      fails++;
      $display("FAIL rw_full: ovf=%b count=%0d dout=%0d last=%0d, want 0/8/1/9", overflow[0], count[0], dout[0], last[0]);
    end
    drain(0, 2);

    do_reset();
    drive(0, 1'b1, W'(5), 1'b1);
    tests++;
    if (underflow[0] !== udf_m[0] || underflow[0] !== 1'b1 || count[0] !== CW'(1) || dvalid[0] !== 1'b0) begin
      fails++;
      $display("FAIL rw_empty: udf=%b count=%0d dvalid=%b, want 1/1/0", underflow[0], count[0], dvalid[0]);
    end
    drive(0, 1'b0, '0, 1'b1);
    tests++;
    if (dout[0] !== W'(5) || dvalid[0] !== 1'b1) begin
      fails++;
      $display("FAIL rw_empty_pop: dout=%0d dvalid=%b, want 5/1", dout[0], dvalid[0]);
    end
  endtask

  task automatic test_mid_reset_clear();
    do_reset();
    for (int i = 1; i <= 6; i++) drive(0, 1'b1, W'(20 + i), 1'b0);
    drive(0, 1'b0, '0, 1'b1);
    tests++;
    if (count[0] !== CW'(5) || dout[0] !== W'(21)) begin
      fails++;
      $display("FAIL pre_arst: count=%0d dout=%0d, want 5/21", count[0], dout[0]);
    end
    #2;
    arst = 1'b1;
    #1;
    tests++;
    if (count[0] !== '0 || empty[0] !== 1'b1 || dout[0] !== '0 || last[0] !== '0 || dvalid[0] !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: count=%0d empty=%b dout=%0d last=%0d dvalid=%b, want 0/1/0/0/0",
               count[0], empty[0], dout[0], last[0], dvalid[0]);
    end
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    model_reset(1'b0);

    drive(0, 1'b0, '0, 1'b1);
    drive(0, 1'b1, W'(7), 1'b0);
    drive(0, 1'b1, W'(8), 1'b0);
    tests++;
    if (underflow[0] !== 1'b1 || count[0] !== CW'(2) || last[0] !== W'(8)) begin
      fails++;
      $display("FAIL pre_clr: udf=%b count=%0d last=%0d, want 1/2/8", underflow[0], count[0], last[0]);
    end
    clr[0]  = 1'b1;
    wren[0] = 1'b1;
    din[0]  = W'(99);
    @(posedge clk);
    #1;
    clr[0]  = 1'b0;
    wren[0] = 1'b0;
    model_reset(1'b1);
    tests++;
    if (count[0] !== '0 || empty[0] !== 1'b1 || last[0] !== last_m[0] || last[0] !== W'(8) || underflow[0] !== 1'b0) begin
      fails++;
      $display("FAIL clr_wren: count=%0d empty=%b last=%0d udf=%b, want 0/1/8/0", count[0], empty[0], last[0], underflow[0]);
    end
    drive(0, 1'b1, W'(42), 1'b0);
    drive(0, 1'b0, '0, 1'b1);
    tests++;
    if (dout[0] !== W'(42) || dvalid[0] !== 1'b1 || count[0] !== '0) begin
      fails++;
      $display("FAIL post_clr: dout=%0d dvalid=%b count=%0d, want 42/1/0", dout[0], dvalid[0], count[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    arst  = 1'b0;
    for (int s = 0; s < 2; s++) begin
      clr[s]  = 1'b0;
      wren[s] = 1'b0;
      rden[s] = 1'b0;
      din[s]  = '0;
    end
    model_reset(1'b0);
    test_reset();
    test_fill_drain();
    test_overwrite();
    test_drop();
    test_simultaneous();
    test_mid_reset_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
